fe_chan_router: RTL and testbench

Parametrised radio front-end channel router between the AD936x-style sample interface and the radio core, all in the radio clock domain.
- Generalises the fixed two-channel calibration swap to NUM_CHANNELS channels, with independently programmable RX and TX permutations.
- Map changes are staged over the settings bus and committed only at a safe point: all channels idle, or on forced commit.
- Each commit is followed by a strobe-gated settle window, so no sample is ever routed under a half-applied map.

---
 rtl/fe_chan_router.sv | 210 +++++++++++++++++++++
 tb/tb_fe_chan_router.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_chan_router.sv
// Radio front-end channel router: programmable RX/TX channel permutations whose staged
// maps are committed only when all channels are idle (or forced), then held in a strobe-gated settle window.
module fe_chan_router #(
  parameter int                NUM_CHANNELS  = 2,
  parameter int                WIDTH         = 32,
  parameter int                AWIDTH        = 8,
  parameter logic [AWIDTH-1:0] SR_BASE       = '0,
  parameter int                SETTLE_CYCLES = 4
) (
  input  logic                          radio_clk,
  input  logic                          radio_rst,
  input  logic                          set_stb,
  input  logic [AWIDTH-1:0]             set_addr,
  input  logic [31:0]                   set_data,
  input  logic [1:0]                    rb_addr,
  output logic [31:0]                   rb_data,
  input  logic [NUM_CHANNELS-1:0]       rx_stb_in,
  input  logic [NUM_CHANNELS*WIDTH-1:0] rx_data_in,
  output logic [NUM_CHANNELS-1:0]       rx_stb_out,
  output logic [NUM_CHANNELS*WIDTH-1:0] rx_data_out,
  input  logic [NUM_CHANNELS-1:0]       tx_stb_in,
  output logic [NUM_CHANNELS-1:0]       tx_stb_out,
  input  logic [NUM_CHANNELS*WIDTH-1:0] tx_data_in,
  output logic [NUM_CHANNELS*WIDTH-1:0] tx_data_out,
  input  logic [NUM_CHANNELS-1:0]       rx_running,
  input  logic [NUM_CHANNELS-1:0]       tx_running,
  input  logic [NUM_CHANNELS*32-1:0]    db_gpio_in,
  output logic [NUM_CHANNELS*32-1:0]    db_gpio_out,
  output logic                          map_busy
);

  localparam int CW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MW   = NUM_CHANNELS * CW;
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNTW-1:0]   CNT_RELOAD = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [AWIDTH-1:0] ADDR_RX    = SR_BASE;
  localparam logic [AWIDTH-1:0] ADDR_TX    = SR_BASE + AWIDTH'(1);
  localparam logic [AWIDTH-1:0] ADDR_CTL   = SR_BASE + AWIDTH'(2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

  function automatic logic [MW-1:0] identity_map();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) m[i*CW +: CW] = CW'(i);
    return m;
  endfunction

  localparam logic [MW-1:0] IDENTITY = identity_map();

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            force_q, force_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     apply_q, apply_d;
  logic [MW-1:0]   act_rx_q, act_rx_d, act_tx_q, act_tx_d;
  logic [MW-1:0]   stg_rx_q, stg_tx_q;

  logic wr_rx, wr_tx, wr_ctl, commit, clr_ovr, safe, settling;

  assign wr_rx    = set_stb && (set_addr == ADDR_RX);
  assign wr_tx    = set_stb && (set_addr == ADDR_TX);
  assign wr_ctl   = set_stb && (set_addr == ADDR_CTL);
  assign commit   = wr_ctl && set_data[0];
  assign clr_ovr  = wr_ctl && set_data[2];
  assign safe     = force_q || !(|rx_running || |tx_running);
  assign settling = (state_q == ST_SETTLE);
  assign map_busy = (state_q != ST_IDLE);

  // Map bits above the used fields carry no meaning.
  logic unused_set_data;
  assign unused_set_data = ^set_data[31:MW];

  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      stg_rx_q <= IDENTITY;
      stg_tx_q <= IDENTITY;
    end else begin
      if (wr_rx) stg_rx_q <= set_data[MW-1:0];
      if (wr_tx) stg_tx_q <= set_data[MW-1:0];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    force_d   = force_q;
    act_rx_d  = act_rx_q;
    act_tx_d  = act_tx_q;
    apply_d   = apply_q;
    // A commit while busy is dropped but flagged; the flag wins over a simultaneous clear.
    overrun_d = (overrun_q && !clr_ovr) || (commit && state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_PENDING;
          force_d = set_data[1];
        end
      end
      ST_PENDING: begin
        if (safe) begin
          act_rx_d = stg_rx_q;
          act_tx_d = stg_tx_q;
          cnt_d    = CNT_RELOAD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          apply_d = apply_q + 16'd1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge radio_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (radio_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      force_q   <= 1'b0;
      overrun_q <= 1'b0;
      apply_q   <= '0;
      act_rx_q  <= IDENTITY;
      act_tx_q  <= IDENTITY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      force_q   <= force_d;
      overrun_q <= overrun_d;
      apply_q   <= apply_d;
      act_rx_q  <= act_rx_d;
      act_tx_q  <= act_tx_d;
    end
  end

  logic [WIDTH-1:0] rx_in_a   [NUM_CHANNELS];
  logic [WIDTH-1:0] tx_in_a   [NUM_CHANNELS];
  logic [31:0]      gpio_in_a [NUM_CHANNELS];
  logic [CW-1:0]    rx_sel    [NUM_CHANNELS];
  logic [CW-1:0]    tx_sel    [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]       rx_stb_d, tx_stb_d;
  logic [NUM_CHANNELS*WIDTH-1:0] rx_data_d, tx_data_d;
  logic [NUM_CHANNELS*32-1:0]    gpio_d;

  always_comb begin
    rx_stb_d  = '0;
    tx_stb_d  = '0;
    rx_data_d = '0;
    tx_data_d = '0;
    gpio_d    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rx_in_a[i]   = rx_data_in[i*WIDTH +: WIDTH];
      tx_in_a[i]   = tx_data_in[i*WIDTH +: WIDTH];
      gpio_in_a[i] = db_gpio_in[i*32 +: 32];
      rx_sel[i]    = act_rx_q[i*CW +: CW];
      tx_sel[i]    = act_tx_q[i*CW +: CW];
    end
    // Out-of-range sources leave the output at zero.
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(rx_sel[i]) < NUM_CHANNELS) begin
        rx_stb_d[i]                 = rx_stb_in[rx_sel[i]];
        rx_data_d[i*WIDTH +: WIDTH] = rx_in_a[rx_sel[i]];
      end
      if (int'(tx_sel[i]) < NUM_CHANNELS) begin
        tx_stb_d[i]                 = tx_stb_in[tx_sel[i]];
        tx_data_d[i*WIDTH +: WIDTH] = tx_in_a[tx_sel[i]];
        gpio_d[i*32 +: 32]          = gpio_in_a[tx_sel[i]];
      end
    end
  end

  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      rx_stb_out  <= '0;
      tx_stb_out  <= '0;
      rx_data_out <= '0;
      tx_data_out <= '0;
      db_gpio_out <= '0;
    end else begin
      rx_stb_out  <= settling ? '0 : rx_stb_d;
      tx_stb_out  <= settling ? '0 : tx_stb_d;
      rx_data_out <= rx_data_d;
      tx_data_out <= tx_data_d;
      if (!settling) db_gpio_out <= gpio_d;
    end
  end

  always_comb begin
    rb_data = '0;
    case (rb_addr)
      2'd0:    rb_data = 32'(act_rx_q);
      2'd1:    rb_data = 32'(act_tx_q);
      2'd2:    rb_data = {13'd0, overrun_q, state_q, apply_q};
      default: rb_data = 32'(stg_rx_q);
    endcase
  end

endmodule

// File: tb/tb_fe_chan_router.sv
// Self-checking bench for fe_chan_router: directed commit scenarios plus randomized traffic,
// compared every cycle against a behavioural model of routing, commit and settle rules.
module tb_fe_chan_router;

  localparam int N      = 3;
  localparam int W      = 16;
  localparam int AW     = 8;
  localparam int SETTLE = 4;
  localparam int CW     = 2;
  localparam logic [AW-1:0] BASE = 8'h10;

  logic            radio_clk = 1'b0;
  logic            radio_rst = 1'b1;
  logic            set_stb   = 1'b0;
  logic [AW-1:0]   set_addr  = '0;
  logic [31:0]     set_data  = '0;
  logic [1:0]      rb_addr   = '0;
  logic [31:0]     rb_data;
  logic [N-1:0]    rx_stb_in = '0;
  logic [N-1:0]    tx_stb_in = '0;
  logic [N-1:0]    rx_running = '0;
  logic [N-1:0]    tx_running = '0;
  logic [N-1:0]    rx_stb_out, tx_stb_out;
  logic [N*W-1:0]  rx_data_in = '0;
  logic [N*W-1:0]  tx_data_in = '0;
  logic [N*W-1:0]  rx_data_out, tx_data_out;
  logic [N*32-1:0] db_gpio_in = '0;
  logic [N*32-1:0] db_gpio_out;
  logic            map_busy;

  always #5 radio_clk = ~radio_clk;

  fe_chan_router #(
    .NUM_CHANNELS (N),
    .WIDTH        (W),
    .AWIDTH       (AW),
    .SR_BASE      (BASE),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .radio_clk  (radio_clk),
    .radio_rst  (radio_rst),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .rb_addr    (rb_addr),
    .rb_data    (rb_data),
    .rx_stb_in  (rx_stb_in),
    .rx_data_in (rx_data_in),
    .rx_stb_out (rx_stb_out),
    .rx_data_out(rx_data_out),
    .tx_stb_in  (tx_stb_in),
    .tx_stb_out (tx_stb_out),
    .tx_data_in (tx_data_in),
    .tx_data_out(tx_data_out),
    .rx_running (rx_running),
    .tx_running (tx_running),
    .db_gpio_in (db_gpio_in),
    .db_gpio_out(db_gpio_out),
    .map_busy   (map_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: maps as channel-number arrays, commit tracked as pending / settle cycles left.
  int m_stg_rx[N];
  int m_stg_tx[N];
  int m_act_rx[N];
  int m_act_tx[N];
  bit m_pending, m_force, m_ovr;
  int m_settle_left, m_applies;

  logic [N-1:0]    e_rx_stb, e_tx_stb;
  logic [N*W-1:0]  e_rx_data, e_tx_data;
  logic [N*32-1:0] e_gpio;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_map(input int f[N]);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m = m | (32'(f[i]) << (CW * i));
    return m;
  endfunction

  function automatic logic [1:0] state_code();
    if (m_pending) return 2'd1;
    if (m_settle_left > 0) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_step();
    bit in_settle, busy, commit, clr;
    int s;
    if (radio_rst) begin
      for (int i = 0; i < N; i++) begin
        m_stg_rx[i] = i; m_stg_tx[i] = i; m_act_rx[i] = i; m_act_tx[i] = i;
      end
      m_pending = 0; m_force = 0; m_ovr = 0; m_settle_left = 0; m_applies = 0;
      e_rx_stb = '0; e_tx_stb = '0; e_rx_data = '0; e_tx_data = '0; e_gpio = '0;
      return;
    end
    in_settle = (m_settle_left > 0);
    busy      = m_pending || in_settle;
    for (int i = 0; i < N; i++) begin
      s = m_act_rx[i];
      e_rx_stb[i] = 1'b0;
      e_rx_data[i*W +: W] = '0;
      if (s < N) begin
        e_rx_stb[i] = !in_settle && rx_stb_in[s];
        e_rx_data[i*W +: W] = rx_data_in[s*W +: W];
      end
      s = m_act_tx[i];
      e_tx_stb[i] = 1'b0;
      e_tx_data[i*W +: W] = '0;
      if (!in_settle) e_gpio[i*32 +: 32] = '0;
      if (s < N) begin
        e_tx_stb[i] = !in_settle && tx_stb_in[s];
        e_tx_data[i*W +: W] = tx_data_in[s*W +: W];
        if (!in_settle) e_gpio[i*32 +: 32] = db_gpio_in[s*32 +: 32];
      end
    end
    commit = set_stb && (set_addr == BASE + 8'd2) && set_data[0];
    clr    = set_stb && (set_addr == BASE + 8'd2) && set_data[2];
    m_ovr  = (m_ovr && !clr) || (commit && busy);
    if (m_pending) begin
      if (m_force || (rx_running == '0 && tx_running == '0)) begin
        m_act_rx = m_stg_rx;
        m_act_tx = m_stg_tx;
        m_pending = 0;
        m_settle_left = SETTLE;
      end
    end else if (in_settle) begin
      m_settle_left--;
      if (m_settle_left == 0) m_applies = (m_applies + 1) % 65536;
    end else if (commit) begin
      m_pending = 1;
      m_force = set_data[1];
    end
    if (set_stb && set_addr == BASE)
      for (int i = 0; i < N; i++) m_stg_rx[i] = int'((set_data >> (CW * i)) & 32'h3);
    if (set_stb && set_addr == BASE + 8'd1)
      for (int i = 0; i < N; i++) m_stg_tx[i] = int'((set_data >> (CW * i)) & 32'h3);
  endtask

  task automatic rand_inputs();
    rx_stb_in  = N'($urandom());
    tx_stb_in  = N'($urandom());
    rx_data_in = (N*W)'({$urandom(), $urandom()});
    tx_data_in = (N*W)'({$urandom(), $urandom()});
    db_gpio_in = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic cycle();
    rand_inputs();
    model_step();
    @(posedge radio_clk);
    #1;
    check("rx_stb_out",  rx_stb_out,  e_rx_stb);
    check("rx_data_out", rx_data_out, e_rx_data);
    check("tx_stb_out",  tx_stb_out,  e_tx_stb);
    check("tx_data_out", tx_data_out, e_tx_data);
    check("db_gpio_out", db_gpio_out, e_gpio);
    check("map_busy",    map_busy,    m_pending || (m_settle_left > 0));
  endtask

  task automatic check_rb();
    logic [31:0] exp_rb [4];
    exp_rb[0] = pack_map(m_act_rx);
    exp_rb[1] = pack_map(m_act_tx);
    exp_rb[2] = {13'd0, m_ovr, state_code(), 16'(m_applies)};
    exp_rb[3] = pack_map(m_stg_rx);
    for (int a = 0; a < 4; a++) begin
      rb_addr = 2'(a);
      #1;
      check($sformatf("rb_data[%0d]", a), rb_data, exp_rb[a]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cycle();
      check_rb();
    end
  endtask

  task automatic sr_write(input int off, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = BASE + AW'(off);
    set_data = data;
    cycle();
    check_rb();
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
  endtask

  task automatic rb_field(input string tag, input logic [31:0] mask, input logic [31:0] exp);
    rb_addr = 2'd2;
    #1;
    check(tag, rb_data & mask, exp);
  endtask

  initial begin
    // Reset and identity routing
    radio_rst = 1'b1;
    run(2);
    radio_rst = 1'b0;
    rb_field("rb_state_after_reset", 32'hFFFF_FFFF, 32'h0);
    run(4);

    // Swap-style commit with all channels idle
    sr_write(0, 32'h21);
    sr_write(1, 32'h06);
    sr_write(2, 32'h1);
    run(8);
    rb_field("apply_count_after_swap", 32'h0000_FFFF, 32'h1);

    // Deferred commit: RX channel 1 busy, staged map rewritten while pending
    rx_running = 3'b010;
    sr_write(0, 32'h2A);
    sr_write(2, 32'h1);
    run(3);
    rb_field("state_pending_deferred", 32'h0003_0000, 32'h0001_0000);
    sr_write(0, 32'h12);
    run(2);
    rx_running = '0;
    run(8);

    // Forced commit with TX running, overrun on a commit during SETTLE, then clear
    tx_running = 3'b111;
    sr_write(1, 32'h18);
    sr_write(2, 32'h3);
    run(1);
    sr_write(2, 32'h1);
    run(6);
    rb_field("overrun_set", 32'h0004_0000, 32'h0004_0000);
    sr_write(2, 32'h4);
    rb_field("overrun_cleared", 32'h0004_0000, 32'h0);
    tx_running = '0;

    // Out-of-range source fields
    sr_write(0, 32'h2C);
    sr_write(1, 32'h27);
    sr_write(2, 32'h1);
    run(8);
    check("rx_oor_data", rx_data_out[W +: W], '0);
    check("tx_oor_gpio", db_gpio_out[31:0], '0);

    // Reset while a commit is pending
    rx_running = 3'b001;
    sr_write(0, 32'h09);
    sr_write(2, 32'h1);
    run(2);
    radio_rst = 1'b1;
    run(1);
    radio_rst = 1'b0;
    rx_running = '0;
    rb_field("state_after_mid_reset", 32'hFFFF_FFFF, 32'h0);
    run(3);

    // Randomized settings traffic and channel activity
    for (int k = 0; k < 400; k++) begin
      radio_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        set_stb  = 1'b1;
        set_addr = BASE + AW'($urandom_range(0, 3));
        set_data = $urandom();
        if (set_addr == BASE + 8'd2 && $urandom_range(0, 1) == 1) set_data[0] = 1'b1;
      end else begin
        set_stb = 1'b0;
      end
      rx_running = ($urandom_range(0, 2) == 0) ? N'($urandom()) : '0;
      tx_running = ($urandom_range(0, 2) == 0) ? N'($urandom()) : '0;
      cycle();
      check_rb();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
